// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// div_pkg : shared state encodings and default width for the sequential divider
// Revision: 1.0
// ============================================================================
package div_pkg;

    localparam int c_WIDTH = 16;

    localparam logic [1:0] c_ST_IDLE = 2'b00;
    localparam logic [1:0] c_ST_RUN  = 2'b01;
    localparam logic [1:0] c_ST_DONE = 2'b10;

    typedef enum logic [1:0] {
        IDLE = c_ST_IDLE,
        RUN  = c_ST_RUN,
        DONE = c_ST_DONE
    } state_t;

endpackage
`default_nettype wire

// File: rtl/addsub_n.sv
`default_nettype none
// ============================================================================
// addsub_n : N-bit ripple adder/subtractor; carry_out=1 on subtract means no borrow
// Revision: 1.0
// ============================================================================
module addsub_n #(
    parameter int N = 17
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         subtract,
    output logic [N-1:0] sum,
    output logic         carry_out
);

    logic [N:0]   w_carry;
    logic [N-1:0] w_b;

    // Two's-complement subtract: invert b and inject the +1 through carry-in
    assign w_b        = b ^ {N{subtract}};
    assign w_carry[0] = subtract;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign sum[i]         = a[i] ^ w_b[i] ^ w_carry[i];
        assign w_carry[i + 1] = (a[i] & w_b[i]) | (w_carry[i] & (a[i] ^ w_b[i]));
    end

    assign carry_out = w_carry[N];

endmodule
`default_nettype wire

// File: rtl/seq_divider16.sv
`default_nettype none
// ============================================================================
// seq_divider16 : restoring unsigned divider, one quotient bit per clock
// Revision: 1.0
// ============================================================================
module seq_divider16
    import div_pkg::*;
#(
    parameter int WIDTH = c_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int c_CNT_W = $clog2(WIDTH + 1);

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH:0]     r_rem;
    logic [WIDTH-1:0]   r_dvd;
    logic [WIDTH-1:0]   r_dvs;

    logic [2*WIDTH:0]   w_pair;
    logic [WIDTH:0]     w_diff;
    logic               w_no_borrow;

    // The dividend register doubles as the quotient: bits shift out the top
    // into the partial remainder while quotient bits enter at the bottom.
    assign w_pair = {r_rem, r_dvd} << 1;

    addsub_n #(
        .N (WIDTH + 1)
    ) u_trial (
        .a         (w_pair[2*WIDTH:WIDTH]),
        .b         ({1'b0, r_dvs}),
        .subtract  (1'b1),
        .sum       (w_diff),
        .carry_out (w_no_borrow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_dvd       <= '0;
            r_dvs       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_dvd       <= dividend;
                            r_dvs       <= divisor;
                            r_rem       <= '0;
                            r_cnt       <= c_CNT_W'(WIDTH);
                            div_by_zero <= 1'b0;
                            r_state     <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (r_cnt == '0) begin
                        quotient  <= r_dvd;
                        remainder <= r_rem[WIDTH-1:0];
                        done      <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_rem <= w_no_borrow ? w_diff : w_pair[2*WIDTH:WIDTH];
                        r_dvd <= w_pair[WIDTH-1:0] | {{(WIDTH-1){1'b0}}, w_no_borrow};
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider16.sv
`default_nettype none
// ============================================================================
// tb_seq_divider16 : directed and random checks of seq_divider16 against / and %
// Revision: 1.0
// ============================================================================
module tb_seq_divider16;

    localparam int c_W = 16;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [c_W-1:0] dividend;
    logic [c_W-1:0] divisor;
    logic           busy;
    logic           done;
    logic [c_W-1:0] quotient;
    logic [c_W-1:0] remainder;
    logic           div_by_zero;

    int n_tests = 0;
    int n_fail  = 0;

    seq_divider16 #(
        .WIDTH (c_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One division: start held for one edge, operands scrambled while busy,
    // optional stray start pulses in RUN (pulse_run) and in DONE (pulse_done).
    task automatic do_div(input logic [c_W-1:0] a, input logic [c_W-1:0] b,
                          input int pulse_run, input bit pulse_done);
        logic [c_W-1:0] eq;
        logic [c_W-1:0] er;
        logic           edbz;
        int             exp_lat;
        int             lat;
        int             seen;
        if (b == '0) begin
            eq = '1; er = a; edbz = 1'b1; exp_lat = 0;
        end else begin
            eq = a / b; er = a % b; edbz = 1'b0; exp_lat = c_W + 1;
        end
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_start", 32'(busy), 32'd1);
        lat = 0;
        while (!done && lat < 40) begin
            dividend = 16'($urandom);
            divisor  = 16'($urandom);
            start    = (lat == pulse_run);
            @(posedge clk);
            #1;
            start = 1'b0;
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("quotient", 32'(quotient), 32'(eq));
        check("remainder", 32'(remainder), 32'(er));
        check("div_by_zero", 32'(div_by_zero), 32'(edbz));
        if (pulse_done) begin
            dividend = 16'd50;
            divisor  = 16'd5;
            start    = 1'b1;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        check("done_pulse", 32'(done), 32'd0);
        check("busy_end", 32'(busy), 32'd0);
        check("quot_hold", 32'(quotient), 32'(eq));
        if (pulse_done) begin
            seen = 0;
            repeat (25) begin
                @(posedge clk);
                #1;
                if (done || busy) seen++;
            end
            check("ignored_start", 32'(seen), 32'd0);
            check("rem_hold", 32'(remainder), 32'(er));
        end
    endtask

    initial begin
        int seen;
        logic [c_W-1:0] ra;
        logic [c_W-1:0] rb;
        int sel;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quot", 32'(quotient), 32'd0);
        check("rst_rem", 32'(remainder), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_div(16'd100, 16'd7, -1, 1'b0);
        do_div(16'hFFFF, 16'd1, -1, 1'b0);
        do_div(16'hFFFF, 16'hFFFF, -1, 1'b0);
        do_div(16'd3, 16'd10, -1, 1'b0);
        do_div(16'd0, 16'd5, -1, 1'b0);
        do_div(16'd5, 16'd0, -1, 1'b0);
        do_div(16'd9, 16'd3, -1, 1'b0);
        do_div(16'd200, 16'd9, 4, 1'b1);

        // Abort 1000/3 mid-run: outputs must clear without waiting for a clock
        @(negedge clk);
        dividend = 16'd1000;
        divisor  = 16'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_quot", 32'(quotient), 32'd0);
        check("abort_rem", 32'(remainder), 32'd0);
        check("abort_dbz", 32'(div_by_zero), 32'd0);
        seen = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done || busy) seen++;
        end
        check("abort_no_done", 32'(seen), 32'd0);
        do_div(16'd1000, 16'd3, -1, 1'b0);

        for (int i = 0; i < 2000; i++) begin
            sel = int'($urandom_range(7, 0));
            ra  = 16'($urandom);
            if (sel == 0)      rb = '0;
            else if (sel <= 2) rb = 16'($urandom_range(15, 1));
            else if (sel == 3) rb = ra;
            else               rb = 16'($urandom);
            do_div(ra, rb, -1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
